// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state encoding
// and a width helper used to size the tick and debounce counters.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bits needed to hold any value 0..max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/button_debounce_fsm.sv
// Per-channel debounce FSM: turns a synchronised, polarity-normalised button
// into a debounced level plus registered press/release/long-press strobes.
module button_debounce_fsm
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic tick,
    input  logic s,
    output logic level,
    output logic press_stb,
    output logic release_stb,
    output logic long_stb
);

    localparam int CW = cnt_width(LONG_TICKS);

    btn_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          long_done, long_done_n;
    logic          level_n, press_n, release_n, long_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            long_done   <= 1'b0;
            level       <= 1'b0;
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
            long_stb    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            long_done   <= long_done_n;
            level       <= level_n;
            press_stb   <= press_n;
            release_stb <= release_n;
            long_stb    <= long_n;
        end
    end

    // A change of s is tested before tick in every state, so it always wins.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        long_done_n = long_done;
        level_n     = level;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        cnt_inc     = cnt + CW'(1);
        case (state)
            IDLE: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                        level_n = 1'b1;
                        press_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end else if (tick && cnt != CW'(LONG_TICKS)) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CW'(LONG_TICKS) && !long_done) begin
                        long_n      = 1'b1;
                        long_done_n = 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                // Returning to PRESSED keeps long_done so a glitch cannot re-arm long.
                if (s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                        state_n     = IDLE;
                        cnt_n       = '0;
                        level_n     = 1'b0;
                        release_n   = 1'b1;
                        long_done_n = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Button front end: synchronises raw pads, normalises polarity, generates the
// shared debounce tick and runs one debounce FSM per channel.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                 NUM_BTN         = 4,
    parameter int                 TICK_DIV        = 12000,
    parameter int                 DEBOUNCE_TICKS  = 10,
    parameter int                 LONG_TICKS      = 1000,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 4'b0001
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int TW = cnt_width(TICK_DIV - 1);

    logic [NUM_BTN-1:0] sync1, sync2, s;
    logic [TW-1:0]      tcnt;
    logic               tick;

    // Synchronisers idle at the inactive pad level so reset never looks like a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= ACTIVE_LOW_MASK;
            sync2 <= ACTIVE_LOW_MASK;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ ACTIVE_LOW_MASK;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TW'(TICK_DIV - 1));
            if (tcnt == TW'(TICK_DIV - 1)) tcnt <= '0;
            else                           tcnt <= tcnt + TW'(1);
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_fsm #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .LONG_TICKS    (LONG_TICKS)
        ) u_fsm (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .tick       (tick),
            .s          (s[i]),
            .level      (btn_level[i]),
            .press_stb  (btn_press[i]),
            .release_stb(btn_release[i]),
            .long_stb   (btn_long[i])
        );
    end

endmodule
